// File: rtl/sum_batch_accumulator_if.sv
// Handshake bundle between the 6-bit adder stage, the batch accumulator and its consumer.
interface sum_batch_accumulator_if #(
  parameter int SUM_W = 7,
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
);
  logic [SUM_W-1:0] sum_in;
  logic             sum_valid;
  logic             sum_ready;
  logic             clear;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             out_ready;
  logic             sat;
  logic [CNT_W-1:0] count;

  modport master (
    output sum_in, sum_valid, clear, out_ready,
    input  sum_ready, acc_out, acc_valid, sat, count
  );

  modport slave (
    input  sum_in, sum_valid, clear, out_ready,
    output sum_ready, acc_out, acc_valid, sat, count
  );
endinterface

// File: rtl/sum_batch_accumulator.sv
// Sums BATCH accepted adder results into a saturating register and presents the total
// over a valid/ready handshake; input is stalled while a finished batch waits.
module sum_batch_accumulator #(
  parameter int SUM_W = 7,
  parameter int ACC_W = 8,
  parameter int BATCH = 4,
  parameter int CNT_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  sum_batch_accumulator_if.slave    bus
);
  typedef enum logic {S_ACC, S_DONE} state_t;

  localparam logic [ACC_W:0]   ACC_MAX  = {1'b0, {ACC_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BATCH - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W:0]   acc_sum;

  // One extra bit so the overflow past 2^ACC_W-1 is visible before clamping.
  assign acc_sum = {1'b0, acc_q} + {{(ACC_W + 1 - SUM_W){1'b0}}, bus.sum_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    if (bus.clear) begin
      state_d = S_ACC;
      acc_d   = '0;
      sat_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_ACC: begin
          if (bus.sum_valid) begin
            if (acc_sum > ACC_MAX) begin
              acc_d = ACC_MAX[ACC_W-1:0];
              sat_d = 1'b1;
            end else begin
              acc_d = acc_sum[ACC_W-1:0];
            end
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = S_DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_d = S_ACC;
            acc_d   = '0;
            sat_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: state_d = S_ACC;
      endcase
    end
  end

  assign bus.sum_ready = (state_q == S_ACC);
  assign bus.acc_valid = (state_q == S_DONE);
  assign bus.acc_out   = acc_q;
  assign bus.sat       = sat_q;
  assign bus.count     = cnt_q;
endmodule
